// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared owner and state types for the bus arbiter
package bus_arbiter_pkg;
    typedef enum logic {OWNER_INSTR = 1'b0, OWNER_DATA = 1'b1} arb_owner_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_HOLD_I, ARB_HOLD_D} arb_state_t;
endpackage

// File: rtl/owner_fifo.sv
// owner_fifo: in-order record of which requester issued each outstanding read
module owner_fifo
    import bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  arb_owner_t             din,
    output arb_owner_t             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    arb_owner_t    slots [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    // DEPTH is a power of two, so the count MSB alone marks full
    assign full    = count[AW];
    assign empty   = count == '0;
    assign dout    = slots[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk)
        if (do_push) slots[wr_ptr] <= din;
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin sharing of one Avalon-MM port between instruction and data requesters
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_W-1:0]      instr_address,
    input  logic [3:0]             instr_byteenable,
    input  logic                   instr_read,
    output logic [31:0]            instr_agent_to_host,
    output logic                   instr_waitrequest,
    output logic                   instr_readdatavalid,
    input  logic [ADDR_W-1:0]      data_address,
    input  logic [3:0]             data_byteenable,
    input  logic                   data_read,
    input  logic                   data_write,
    input  logic [31:0]            data_host_to_agent,
    output logic [31:0]            data_agent_to_host,
    output logic                   data_waitrequest,
    output logic                   data_readdatavalid,
    output logic [ADDR_W-1:0]      mem_address,
    output logic [3:0]             mem_byteenable,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [31:0]            mem_host_to_agent,
    input  logic [31:0]            mem_agent_to_host,
    input  logic                   mem_waitrequest,
    input  logic                   mem_readdatavalid,
    output logic                   grant_owner,
    output logic [$clog2(DEPTH):0] pending_count,
    output logic                   err_stray
);
    arb_state_t state;
    arb_owner_t last_owner;
    arb_owner_t owner;
    arb_owner_t head;
    logic       full;
    logic       empty;
    logic       instr_elig;
    logic       data_elig;
    logic       active;
    logic       sel_d;
    logic       accept;
    logic       push;
    logic       pop;
    assign instr_elig = instr_read && !full;
    assign data_elig  = data_write || (data_read && !full);
    // HOLD locks the owner; in IDLE a tie goes to whoever was not granted last
    assign owner  = state == ARB_HOLD_I ? OWNER_INSTR :
                    state == ARB_HOLD_D ? OWNER_DATA :
                    (instr_elig && data_elig) ? (last_owner == OWNER_DATA ? OWNER_INSTR : OWNER_DATA) :
                    instr_elig ? OWNER_INSTR : OWNER_DATA;
    assign active = state != ARB_IDLE || instr_elig || data_elig;
    assign sel_d  = owner == OWNER_DATA;
    assign mem_address       = sel_d ? data_address : instr_address;
    assign mem_byteenable    = sel_d ? data_byteenable : instr_byteenable;
    assign mem_host_to_agent = sel_d ? data_host_to_agent : '0;
    assign mem_read          = rst && active && (sel_d ? data_read : instr_read);
    assign mem_write         = rst && active && sel_d && data_write;
    assign accept = active && !mem_waitrequest;
    assign push   = accept && mem_read;
    assign pop    = mem_readdatavalid && !empty;
    assign instr_readdatavalid = pop && head == OWNER_INSTR;
    assign data_readdatavalid  = pop && head == OWNER_DATA;
    assign instr_agent_to_host = instr_readdatavalid ? mem_agent_to_host : '0;
    assign data_agent_to_host  = data_readdatavalid ? mem_agent_to_host : '0;
    assign instr_waitrequest   = instr_read && (active && !sel_d ? mem_waitrequest : 1'b1);
    assign data_waitrequest    = (data_read || data_write) && (active && sel_d ? mem_waitrequest : 1'b1);
    owner_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (owner),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (pending_count)
    );
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ARB_IDLE;
            last_owner  <= OWNER_DATA;
            grant_owner <= OWNER_INSTR;
            err_stray   <= 1'b0;
        end else begin
            err_stray <= mem_readdatavalid && empty;
            if (active) grant_owner <= owner;
            if (accept) last_owner <= owner;
            state <= (!active || !mem_waitrequest) ? ARB_IDLE : sel_d ? ARB_HOLD_D : ARB_HOLD_I;
        end
    end
    a_rw_excl: assert property (@(posedge clk) disable iff (!rst) !(data_read && data_write));
    a_hold_i:  assert property (@(posedge clk) disable iff (!rst) state == ARB_HOLD_I |-> instr_read);
    a_hold_d:  assert property (@(posedge clk) disable iff (!rst) state == ARB_HOLD_D |-> (data_read || data_write));
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scoreboard bench for bus_arbiter
module tb_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_address, data_address, mem_address;
    logic [3:0]  instr_byteenable, data_byteenable, mem_byteenable;
    logic        instr_read, data_read, data_write, mem_read, mem_write;
    logic [31:0] instr_agent_to_host, data_agent_to_host, data_host_to_agent;
    logic [31:0] mem_host_to_agent, mem_agent_to_host;
    logic        instr_waitrequest, instr_readdatavalid, data_waitrequest, data_readdatavalid;
    logic        mem_waitrequest, mem_readdatavalid, grant_owner, err_stray;
    logic [2:0]  pending_count;

    typedef struct {logic wr; logic [31:0] addr; logic [31:0] wdata;} cmd_t;
    typedef struct {logic port; logic [31:0] data;} rsp_t;
    cmd_t cmd_q[$];
    rsp_t rsp_q[$];
    cmd_t ec;
    rsp_t er;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.DEPTH(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .instr_address(instr_address), .instr_byteenable(instr_byteenable), .instr_read(instr_read),
        .instr_agent_to_host(instr_agent_to_host), .instr_waitrequest(instr_waitrequest),
        .instr_readdatavalid(instr_readdatavalid),
        .data_address(data_address), .data_byteenable(data_byteenable), .data_read(data_read),
        .data_write(data_write), .data_host_to_agent(data_host_to_agent),
        .data_agent_to_host(data_agent_to_host), .data_waitrequest(data_waitrequest),
        .data_readdatavalid(data_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read),
        .mem_write(mem_write), .mem_host_to_agent(mem_host_to_agent),
        .mem_agent_to_host(mem_agent_to_host), .mem_waitrequest(mem_waitrequest),
        .mem_readdatavalid(mem_readdatavalid),
        .grant_owner(grant_owner), .pending_count(pending_count), .err_stray(err_stray)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic port, input logic [31:0] d);
        mem_readdatavalid = 1'b1;
        mem_agent_to_host = d;
        rsp_q.push_back('{port, d});
        tick();
        mem_readdatavalid = 1'b0;
    endtask

    // monitor: every accepted command and every routed response is matched against the queues
    always @(negedge clk) begin
        if (rst) begin
            if ((mem_read || mem_write) && !mem_waitrequest) begin
                if (cmd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL cmd_unexpected: got addr %h expected no command", mem_address);
                end else begin
                    ec = cmd_q.pop_front();
                    chk("cmd_write", mem_write, ec.wr);
                    chk("cmd_read", mem_read, !ec.wr);
                    chk("cmd_addr", mem_address, ec.addr);
                    if (ec.wr) chk("cmd_wdata", mem_host_to_agent, ec.wdata);
                end
            end
            if (instr_readdatavalid || data_readdatavalid) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got instr=%0b data=%0b expected none",
                             instr_readdatavalid, data_readdatavalid);
                end else begin
                    er = rsp_q.pop_front();
                    chk("rsp_both", instr_readdatavalid && data_readdatavalid, 0);
                    chk("rsp_port", data_readdatavalid, er.port);
                    chk("rsp_data", data_readdatavalid ? data_agent_to_host : instr_agent_to_host, er.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 0; instr_address = 0; instr_byteenable = 4'hF; instr_read = 0;
        data_address = 0; data_byteenable = 4'hF; data_read = 0; data_write = 0;
        data_host_to_agent = 0; mem_agent_to_host = 0; mem_waitrequest = 0; mem_readdatavalid = 0;
        tick(); tick();
        // reset state
        chk("rst_pending", pending_count, 0);
        chk("rst_err", err_stray, 0);
        chk("rst_grant", grant_owner, 0);
        instr_read = 1; #1;
        chk("rst_mem_read", mem_read, 0);
        instr_read = 0;
        rst = 1;
        // single fetch
        instr_address = 32'h100; instr_read = 1;
        cmd_q.push_back('{1'b0, 32'h100, 32'h0});
        tick();
        instr_read = 0;
        chk("t1_pending1", pending_count, 1);
        tick();
        mem_readdatavalid = 1; mem_agent_to_host = 32'h13; #1;
        chk("t1_data_rdv", data_readdatavalid, 0);
        chk("t1_instr_rdv", instr_readdatavalid, 1);
        mem_readdatavalid = 0;
        respond(1'b0, 32'h13);
        chk("t1_pending0", pending_count, 0);
        // contention after reset: I,D,I,D,I
        rst = 0; tick(); rst = 1;
        instr_address = 32'h104; instr_read = 1;
        data_address = 32'h204; data_host_to_agent = 32'hA5A5_0001; data_write = 1;
        for (int i = 0; i < 5; i++) begin
            cmd_q.push_back(i % 2 ? '{1'b1, 32'h204, 32'hA5A5_0001} : '{1'b0, 32'h104, 32'h0});
            #1;
            chk($sformatf("t2_grant%0d", i), mem_address, i % 2 ? 32'h204 : 32'h104);
            chk($sformatf("t2_dwait%0d", i), data_waitrequest, i % 2 ? 0 : 1);
            tick();
        end
        instr_read = 0; data_write = 0;
        chk("t2_pending3", pending_count, 3);
        for (int i = 1; i <= 3; i++) respond(1'b0, 32'h11 * i);
        chk("t2_pending0", pending_count, 0);
        // hold: data write stalled 3 cycles while instr waits
        data_address = 32'h200; data_host_to_agent = 32'hDEAD_BEEF; data_write = 1;
        instr_address = 32'h108; instr_read = 1;
        cmd_q.push_back('{1'b1, 32'h200, 32'hDEAD_BEEF});
        cmd_q.push_back('{1'b0, 32'h108, 32'h0});
        for (int i = 0; i < 4; i++) begin
            mem_waitrequest = i < 3; #1;
            chk($sformatf("t3_addr%0d", i), mem_address, 32'h200);
            chk($sformatf("t3_wdata%0d", i), mem_host_to_agent, 32'hDEAD_BEEF);
            chk($sformatf("t3_iwait%0d", i), instr_waitrequest, 1);
            chk($sformatf("t3_dwait%0d", i), data_waitrequest, i < 3);
            tick();
        end
        data_write = 0; #1;
        chk("t3_instr_next", mem_address, 32'h108);
        chk("t3_iwait_next", instr_waitrequest, 0);
        tick();
        instr_read = 0;
        respond(1'b0, 32'h33);
        // full FIFO
        instr_address = 32'h400; instr_read = 1;
        for (int i = 0; i < 5; i++) cmd_q.push_back('{1'b0, 32'h400, 32'h0});
        for (int i = 0; i < 4; i++) tick();
        chk("t4_full_count", pending_count, 4);
        chk("t4_full_wait", instr_waitrequest, 1);
        chk("t4_full_noread", mem_read, 0);
        respond(1'b0, 32'hA0);
        chk("t4_count3", pending_count, 3);
        chk("t4_wait_clear", instr_waitrequest, 0);
        tick();
        instr_read = 0;
        chk("t4_count4", pending_count, 4);
        for (int i = 1; i <= 4; i++) respond(1'b0, 32'hA0 + i);
        // ordering
        instr_address = 32'h10; instr_read = 1;
        cmd_q.push_back('{1'b0, 32'h10, 32'h0});
        tick();
        instr_read = 0; data_address = 32'h20; data_read = 1;
        cmd_q.push_back('{1'b0, 32'h20, 32'h0});
        tick();
        data_read = 0; instr_address = 32'h30; instr_read = 1;
        cmd_q.push_back('{1'b0, 32'h30, 32'h0});
        tick();
        instr_read = 0;
        chk("t5_pending3", pending_count, 3);
        respond(1'b0, 32'hA);
        respond(1'b1, 32'hB);
        respond(1'b0, 32'hC);
        // reset mid-flight
        instr_address = 32'h50; instr_read = 1;
        cmd_q.push_back('{1'b0, 32'h50, 32'h0});
        tick();
        instr_address = 32'h54;
        cmd_q.push_back('{1'b0, 32'h54, 32'h0});
        tick();
        instr_read = 0;
        chk("t6_pending2", pending_count, 2);
        rst = 0; tick(); rst = 1;
        chk("t6_pending_rst", pending_count, 0);
        mem_readdatavalid = 1; mem_agent_to_host = 32'hBAD; #1;
        chk("t6_no_rdv", instr_readdatavalid, 0);
        tick();
        chk("t6_stray1", err_stray, 1);
        tick();
        chk("t6_stray2", err_stray, 1);
        chk("t6_pending0", pending_count, 0);
        mem_readdatavalid = 0;
        tick();
        chk("t6_stray_end", err_stray, 0);
        chk("end_cmd_q", cmd_q.size(), 0);
        chk("end_rsp_q", rsp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
